// File: rtl/isa_pkg.sv
// ISA definitions shared by the sequencer, the decoder, the ALU and the bench.
// Covers field positions, opcode and sub-opcode values, the ALU operation codes and the FSM states.
package isa_pkg;

    localparam int OPC_HI = 30;
    localparam int OPC_LO = 25;
    localparam int RT_HI  = 24;
    localparam int RT_LO  = 20;
    localparam int RA_HI  = 19;
    localparam int RA_LO  = 15;
    localparam int RB_HI  = 14;
    localparam int RB_LO  = 10;
    localparam int SUB_HI = 4;
    localparam int SUB_LO = 0;

    localparam logic [5:0] OPC_RR   = 6'b100000;
    localparam logic [5:0] OPC_ADDI = 6'b101000;
    localparam logic [5:0] OPC_ORI  = 6'b101100;
    localparam logic [5:0] OPC_XORI = 6'b101011;
    localparam logic [5:0] OPC_MOVI = 6'b100010;

    localparam logic [4:0] SUB_ADD   = 5'b00000;
    localparam logic [4:0] SUB_SUB   = 5'b00001;
    localparam logic [4:0] SUB_AND   = 5'b00010;
    localparam logic [4:0] SUB_XOR   = 5'b00011;
    localparam logic [4:0] SUB_OR    = 5'b00100;
    localparam logic [4:0] SUB_SLLI  = 5'b01000;
    localparam logic [4:0] SUB_ROTRI = 5'b01011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_ROTR  = 4'd6,
        ALU_PASSB = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder.
// Maps an instruction word to the ALU operation, the B-operand source, the extended immediate and a legal flag.
module instr_decoder
    import isa_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       ir,
    output alu_op_e           alu_op,
    output logic              alu_src_imm,
    output logic [DATA_W-1:0] imm,
    output logic              legal
);

    logic [5:0] opc;
    logic [4:0] sub;

    assign opc = ir[OPC_HI:OPC_LO];
    assign sub = ir[SUB_HI:SUB_LO];

    always_comb begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        imm         = '0;
        legal       = 1'b0;
        // A set bit 31 marks the word undecodable whatever the opcode says.
        if (!ir[31]) begin
            case (opc)
                OPC_RR: begin
                    legal = 1'b1;
                    case (sub)
                        SUB_ADD: alu_op = ALU_ADD;
                        SUB_SUB: alu_op = ALU_SUB;
                        SUB_AND: alu_op = ALU_AND;
                        SUB_OR:  alu_op = ALU_OR;
                        SUB_XOR: alu_op = ALU_XOR;
                        SUB_SLLI: begin
                            alu_op      = ALU_SLL;
                            alu_src_imm = 1'b1;
                            imm         = {{(DATA_W-5){1'b0}}, ir[RB_HI:RB_LO]};
                        end
                        SUB_ROTRI: begin
                            alu_op      = ALU_ROTR;
                            alu_src_imm = 1'b1;
                            imm         = {{(DATA_W-5){1'b0}}, ir[RB_HI:RB_LO]};
                        end
                        default: legal = 1'b0;
                    endcase
                end
                OPC_ADDI: begin
                    legal       = 1'b1;
                    alu_op      = ALU_ADD;
                    alu_src_imm = 1'b1;
                    imm         = {{(DATA_W-15){ir[14]}}, ir[14:0]};
                end
                OPC_ORI: begin
                    legal       = 1'b1;
                    alu_op      = ALU_OR;
                    alu_src_imm = 1'b1;
                    imm         = {{(DATA_W-15){1'b0}}, ir[14:0]};
                end
                OPC_XORI: begin
                    legal       = 1'b1;
                    alu_op      = ALU_XOR;
                    alu_src_imm = 1'b1;
                    imm         = {{(DATA_W-15){1'b0}}, ir[14:0]};
                end
                OPC_MOVI: begin
                    legal       = 1'b1;
                    alu_op      = ALU_PASSB;
                    alu_src_imm = 1'b1;
                    imm         = {{(DATA_W-20){ir[19]}}, ir[19:0]};
                end
                default: legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control unit: accepts one instruction per handshake and walks it through DECODE, EXEC and WB.
// Drives the register-file and ALU controls, and tracks overflow and retired instructions.
module instr_sequencer
    import isa_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ir_valid,
    input  logic [31:0]       ir,
    output logic              ir_ready,
    input  logic              alu_overflow,
    output logic [REG_AW-1:0] rf_ra_addr,
    output logic [REG_AW-1:0] rf_rb_addr,
    output logic              rf_rd_en,
    output logic              rf_wr_en,
    output logic [REG_AW-1:0] rf_wr_addr,
    output logic [3:0]        alu_op,
    output logic              alu_src_imm,
    output logic [DATA_W-1:0] imm_out,
    output logic              busy,
    output logic              illegal_instr,
    output logic              ovf_sticky,
    output logic [CNT_W-1:0]  retired_cnt
);

    state_e            state_q, state_d;
    logic [31:0]       ir_p0;
    alu_op_e           dec_op;
    logic              dec_src_imm;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_legal;
    logic              active;

    instr_decoder #(.DATA_W(DATA_W)) u_dec (
        .ir          (ir_p0),
        .alu_op      (dec_op),
        .alu_src_imm (dec_src_imm),
        .imm         (dec_imm),
        .legal       (dec_legal)
    );

    assign active = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ir_p0       <= '0;
            ovf_sticky  <= 1'b0;
            retired_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (ir_valid && state_q == ST_IDLE)
                ir_p0 <= ir;
            // Only the arithmetic ops can overflow; ADDI decodes to ALU_ADD.
            if (state_q == ST_EXEC && alu_overflow && (dec_op == ALU_ADD || dec_op == ALU_SUB))
                ovf_sticky <= 1'b1;
            if (state_q == ST_WB)
                retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        ir_ready      = 1'b0;
        busy          = active;
        rf_rd_en      = 1'b0;
        rf_wr_en      = 1'b0;
        illegal_instr = 1'b0;
        // Decoded fields are held through WB and forced to zero while idle.
        rf_ra_addr    = active ? REG_AW'(ir_p0[RA_HI:RA_LO]) : '0;
        rf_rb_addr    = active ? REG_AW'(ir_p0[RB_HI:RB_LO]) : '0;
        rf_wr_addr    = active ? REG_AW'(ir_p0[RT_HI:RT_LO]) : '0;
        alu_op        = active ? dec_op : '0;
        alu_src_imm   = active ? dec_src_imm : 1'b0;
        imm_out       = active ? dec_imm : '0;
        case (state_q)
            ST_IDLE: begin
                ir_ready = 1'b1;
                if (ir_valid)
                    state_d = ST_DECODE;
            end
            ST_DECODE: begin
                rf_rd_en      = dec_legal;
                illegal_instr = ~dec_legal;
                state_d       = dec_legal ? ST_EXEC : ST_IDLE;
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                rf_wr_en = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed instructions with hand-computed write-back expectations.
module tb_instr_sequencer;
    import isa_pkg::*;

    logic        clk;
    logic        reset;
    logic        ir_valid;
    logic [31:0] ir;
    logic        ir_ready;
    logic        alu_overflow;
    logic [4:0]  rf_ra_addr, rf_rb_addr, rf_wr_addr;
    logic        rf_rd_en, rf_wr_en;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic [31:0] imm_out;
    logic        busy, illegal_instr, ovf_sticky;
    logic [15:0] retired_cnt;

    instr_sequencer #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .ir_valid      (ir_valid),
        .ir            (ir),
        .ir_ready      (ir_ready),
        .alu_overflow  (alu_overflow),
        .rf_ra_addr    (rf_ra_addr),
        .rf_rb_addr    (rf_rb_addr),
        .rf_rd_en      (rf_rd_en),
        .rf_wr_en      (rf_wr_en),
        .rf_wr_addr    (rf_wr_addr),
        .alu_op        (alu_op),
        .alu_src_imm   (alu_src_imm),
        .imm_out       (imm_out),
        .busy          (busy),
        .illegal_instr (illegal_instr),
        .ovf_sticky    (ovf_sticky),
        .retired_cnt   (retired_cnt)
    );

    typedef struct {
        bit          illegal;
        logic [4:0]  addr;
        logic [3:0]  op;
        bit          src;
        logic [31:0] imm;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mkexp(bit ill, logic [4:0] addr, alu_op_e op, bit src, logic [31:0] imm);
        exp_t e;
        e.illegal = ill;
        e.addr    = addr;
        e.op      = op;
        e.src     = src;
        e.imm     = imm;
        return e;
    endfunction

    function automatic logic [31:0] rr(logic [4:0] sub, logic [4:0] rt, logic [4:0] ra, logic [4:0] rb);
        return {1'b0, OPC_RR, rt, ra, rb, 5'b0, sub};
    endfunction

    function automatic logic [31:0] ri(logic [5:0] opc, logic [4:0] rt, logic [4:0] ra, logic [14:0] imm);
        return {1'b0, opc, rt, ra, imm};
    endfunction

    // Monitor: every WB cycle and every illegal pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!reset && (rf_wr_en || illegal_instr)) begin
            if (sbq.size() == 0) begin
                check("unexpected_output", {62'd0, rf_wr_en, illegal_instr}, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("kind_illegal", {63'd0, illegal_instr}, {63'd0, e.illegal});
                check("kind_write", {63'd0, rf_wr_en}, {63'd0, !e.illegal});
                if (!e.illegal) begin
                    check("wr_addr", {59'd0, rf_wr_addr}, {59'd0, e.addr});
                    check("alu_op", {60'd0, alu_op}, {60'd0, e.op});
                    check("alu_src_imm", {63'd0, alu_src_imm}, {63'd0, e.src});
                    check("imm_out", {32'd0, imm_out}, {32'd0, e.imm});
                end
            end
        end
    end

    // Starts at a negedge, returns at the negedge after the accepting edge (DECODE).
    task automatic issue(input logic [31:0] instr, input exp_t e, input bit push, input bit hold,
                         output int acc);
        int w;
        ir       = instr;
        ir_valid = 1'b1;
        w = 0;
        while (!ir_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!ir_ready) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        if (push) sbq.push_back(e);
        @(negedge clk);
        acc = cyc;
        if (!hold) ir_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (busy) check("idle_timeout", 64'd0, 64'd1);
    endtask

    int a1, a2;

    initial begin
        reset        = 1'b1;
        ir_valid     = 1'b0;
        ir           = '0;
        alu_overflow = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ctrl", {57'd0, ir_ready, busy, rf_rd_en, rf_wr_en, illegal_instr, alu_src_imm, ovf_sticky},
              {57'd0, 7'b1000000});
        check("reset_fields", {44'd0, rf_ra_addr, rf_rb_addr, rf_wr_addr, alu_op}, 64'd0);
        check("reset_imm_cnt", {16'd0, imm_out, retired_cnt}, 64'd0);

        // ADDI R0,R0,13: write three cycles after accept.
        issue(ri(OPC_ADDI, 5'd0, 5'd0, 15'd13), mkexp(0, 5'd0, ALU_ADD, 1, 32'd13), 1, 0, a1);
        check("addi_decode", {61'd0, rf_rd_en, busy, ir_ready}, {61'd0, 3'b110});
        check("addi_imm_decode", {32'd0, imm_out}, 64'd13);
        @(negedge clk);
        check("addi_exec_no_wr", {63'd0, rf_wr_en}, 64'd0);
        @(negedge clk);
        check("addi_wb_wr", {63'd0, rf_wr_en}, 64'd1);
        wait_idle();
        check("cnt_after_addi", {48'd0, retired_cnt}, 64'd1);

        // MOVI R2,0xFFFFF sign-extends to all ones.
        issue({1'b0, OPC_MOVI, 5'd2, 20'hFFFFF}, mkexp(0, 5'd2, ALU_PASSB, 1, 32'hFFFF_FFFF), 1, 0, a1);
        wait_idle();

        // Back-to-back with valid held high.
        issue(rr(SUB_ADD, 5'd3, 5'd0, 5'd1), mkexp(0, 5'd3, ALU_ADD, 0, 32'd0), 1, 1, a1);
        issue(rr(SUB_SUB, 5'd4, 5'd0, 5'd1), mkexp(0, 5'd4, ALU_SUB, 0, 32'd0), 1, 0, a2);
        check("b2b_spacing", 64'(a2 - a1), 64'd4);
        wait_idle();
        check("cnt_after_b2b", {48'd0, retired_cnt}, 64'd4);
        check("ovf_clear", {63'd0, ovf_sticky}, 64'd0);

        // Overflow during a logical op must not set the sticky flag.
        issue(ri(OPC_XORI, 5'd5, 5'd1, 15'h7FFF), mkexp(0, 5'd5, ALU_XOR, 1, 32'h7FFF), 1, 0, a1);
        @(negedge clk);
        alu_overflow = 1'b1;
        @(negedge clk);
        alu_overflow = 1'b0;
        wait_idle();
        check("ovf_xori_ignored", {63'd0, ovf_sticky}, 64'd0);

        // Overflow during ADD sets it; write still happens.
        issue(rr(SUB_ADD, 5'd6, 5'd0, 5'd1), mkexp(0, 5'd6, ALU_ADD, 0, 32'd0), 1, 0, a1);
        @(negedge clk);
        alu_overflow = 1'b1;
        @(negedge clk);
        alu_overflow = 1'b0;
        wait_idle();
        check("ovf_add_set", {63'd0, ovf_sticky}, 64'd1);

        // Shift/rotate immediates come from the rb field.
        issue(rr(SUB_SLLI, 5'd8, 5'd0, 5'd4), mkexp(0, 5'd8, ALU_SLL, 1, 32'd4), 1, 0, a1);
        wait_idle();
        issue(rr(SUB_ROTRI, 5'd9, 5'd1, 5'd8), mkexp(0, 5'd9, ALU_ROTR, 1, 32'd8), 1, 0, a1);
        wait_idle();
        check("cnt_after_shifts", {48'd0, retired_cnt}, 64'd8);
        check("ovf_persists", {63'd0, ovf_sticky}, 64'd1);

        // Illegal opcode, illegal sub-opcode, and bit 31 set.
        issue({1'b0, 6'b111111, 25'h0123456}, mkexp(1, 5'd0, ALU_ADD, 0, 32'd0), 1, 0, a1);
        check("illegal_pulse", {63'd0, illegal_instr}, 64'd1);
        @(negedge clk);
        check("illegal_one_cycle", {62'd0, illegal_instr, busy}, 64'd0);
        issue(rr(5'b00101, 5'd10, 5'd1, 5'd2), mkexp(1, 5'd0, ALU_ADD, 0, 32'd0), 1, 0, a1);
        wait_idle();
        issue(rr(SUB_ADD, 5'd11, 5'd1, 5'd2) | 32'h8000_0000, mkexp(1, 5'd0, ALU_ADD, 0, 32'd0), 1, 0, a1);
        wait_idle();
        check("cnt_after_illegal", {48'd0, retired_cnt}, 64'd8);

        // Reset during EXEC aborts the instruction.
        issue(rr(SUB_ADD, 5'd7, 5'd0, 5'd1), mkexp(0, 5'd7, ALU_ADD, 0, 32'd0), 0, 0, a1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_wr", {62'd0, rf_wr_en, busy}, 64'd0);
        end
        check("abort_ready", {63'd0, ir_ready}, 64'd1);
        check("abort_cnt_ovf", {47'd0, ovf_sticky, retired_cnt}, 64'd0);
        check("abort_fields", {12'd0, rf_wr_addr, alu_op, imm_out, rf_ra_addr, rf_rb_addr, alu_src_imm}, 64'd0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
